seq_divider_ctrl: RTL and testbench

Sequential 4-bit unsigned restoring divider controller for the divider top module. Accepts a dividend/divisor pair on a start pulse and runs four shift-subtract-restore iterations through one instance of the existing four_bit_subtractor. It presents quotient, remainder and a one-cycle done pulse to the ALSU result path. The block owns operand capture, the iteration counter, restore decisions and divide-by-zero handling.

---
 rtl/seq_divider_ctrl.sv | 125 ++++++++++++
 tb/tb_seq_divider_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider_ctrl.sv
// Sequential 4-bit unsigned restoring divider: one subtractor, four
// shift-subtract-restore iterations per operation, divide-by-zero shortcut.
module four_bit_subtractor (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Bin,
    output logic [3:0] Difference,
    output logic       BorrowOut
);
    logic [4:0] full;

    always_comb begin
        full       = {1'b0, A} - {1'b0, B} - {4'b0000, Bin};
        Difference = full[3:0];
        BorrowOut  = full[4];
    end
endmodule

module seq_divider_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Start,
    input  logic       Abort,
    input  logic [3:0] Dividend,
    input  logic [3:0] Divisor,
    output logic [3:0] Quotient,
    output logic [3:0] Remainder,
    output logic       Busy,
    output logic       Done,
    output logic       DivByZero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [3:0] q_reg;
    logic [3:0] d_reg;
    // Partial remainder bit 4 is always 0 after an update, so only [3:0] is stored.
    logic [3:0] r_reg;
    logic [1:0] cnt;

    logic [4:0] rs;
    logic [3:0] diff;
    logic       borrow;
    logic       success;
    logic [3:0] r_next;
    logic [3:0] q_next;

    four_bit_subtractor u_sub (
        .A          (rs[3:0]),
        .B          (d_reg),
        .Bin        (1'b0),
        .Difference (diff),
        .BorrowOut  (borrow)
    );

    always_comb begin
        rs      = {r_reg, q_reg[3]};
        success = rs[4] | ~borrow;
        r_next  = success ? diff : rs[3:0];
        q_next  = {q_reg[2:0], success};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        Busy <= 1'b1;
                        if (Divisor == '0) begin
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            DivByZero <= 1'b1;
                            Done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            q_reg <= Dividend;
                            d_reg <= Divisor;
                            r_reg <= '0;
                            cnt   <= 2'd3;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Abort wins even over the final iteration.
                    if (Abort) begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        q_reg <= q_next;
                        r_reg <= r_next;
                        cnt   <= cnt - 2'd1;
                        if (cnt == 2'd0) begin
                            Quotient  <= q_next;
                            Remainder <= r_next;
                            DivByZero <= 1'b0;
                            Done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Directed, table-driven bench for seq_divider_ctrl with hand-written
// sequences for start-during-run, abort, divide-by-zero and async reset.
module tb_seq_divider_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Start = 1'b0;
    logic       Abort = 1'b0;
    logic [3:0] Dividend = '0;
    logic [3:0] Divisor = '0;
    logic [3:0] Quotient;
    logic [3:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivByZero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .Abort     (Abort),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dvd;
        logic [3:0] dvs;
        logic [3:0] exp_q;
        logic [3:0] exp_r;
        logic       exp_z;
        int         exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and check acceptance, latency, results and return to idle.
    task automatic run_div(input logic [3:0] dvd, input logic [3:0] dvs,
                           input logic [3:0] eq, input logic [3:0] er,
                           input logic ez, input int elat, input string tag);
        int lat;
        bit seen;
        Dividend = dvd;
        Divisor  = dvs;
        Start    = 1'b1;
        tick();
        Start    = 1'b0;
        Dividend = 4'($urandom);
        Divisor  = 4'($urandom);
        chk($sformatf("%s busy_at_accept", tag), int'(Busy), 1);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 12) begin
            if (Done) seen = 1;
            else begin
                tick();
                lat++;
            end
        end
        chk($sformatf("%s done_latency", tag), lat, elat);
        chk($sformatf("%s quotient", tag), int'(Quotient), int'(eq));
        chk($sformatf("%s remainder", tag), int'(Remainder), int'(er));
        chk($sformatf("%s divbyzero", tag), int'(DivByZero), int'(ez));
        tick();
        chk($sformatf("%s done_cleared", tag), int'(Done), 0);
        chk($sformatf("%s busy_cleared", tag), int'(Busy), 0);
    endtask

    initial begin
        int dones;

        vecs.push_back('{4'd13, 4'd4,  4'd3,  4'd1, 1'b0, 4});
        vecs.push_back('{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 4});
        vecs.push_back('{4'd3,  4'd7,  4'd0,  4'd3, 1'b0, 4});
        vecs.push_back('{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 4});
        vecs.push_back('{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 4});
        vecs.push_back('{4'd14, 4'd3,  4'd4,  4'd2, 1'b0, 4});
        vecs.push_back('{4'd9,  4'd0,  4'hF,  4'd9, 1'b1, 0});
        vecs.push_back('{4'd8,  4'd3,  4'd2,  4'd2, 1'b0, 4});
        vecs.push_back('{4'd7,  4'd2,  4'd3,  4'd1, 1'b0, 4});

        #3;
        chk("reset quotient", int'(Quotient), 0);
        chk("reset remainder", int'(Remainder), 0);
        chk("reset busy", int'(Busy), 0);
        chk("reset done", int'(Done), 0);
        chk("reset divbyzero", int'(DivByZero), 0);
        #19 rst_n = 1'b1;
        tick();

        foreach (vecs[i])
            run_div(vecs[i].dvd, vecs[i].dvs, vecs[i].exp_q, vecs[i].exp_r,
                    vecs[i].exp_z, vecs[i].exp_lat, $sformatf("vec%0d", i));

        for (int a = 0; a < 16; a++)
            for (int b = 1; b < 16; b++)
                run_div(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 4,
                        $sformatf("sweep %0d/%0d", a, b));

        // Second Start two cycles into 13/4 must be ignored.
        Dividend = 4'd13; Divisor = 4'd4; Start = 1'b1;
        tick();
        Start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) begin
                Dividend = 4'd5; Divisor = 4'd1; Start = 1'b1;
            end
            tick();
            Start = 1'b0;
            if (Done) dones++;
        end
        chk("restart_ignored done_count", dones, 1);
        chk("restart_ignored quotient", int'(Quotient), 3);
        chk("restart_ignored remainder", int'(Remainder), 1);

        // Abort at the second RUN edge of 14/3.
        Dividend = 4'd14; Divisor = 4'd3; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("abort busy", int'(Busy), 0);
        chk("abort done", int'(Done), 0);
        chk("abort quotient_kept", int'(Quotient), 3);
        chk("abort remainder_kept", int'(Remainder), 1);
        run_div(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 4, "after_abort");

        // Asynchronous reset in the middle of RUN.
        Dividend = 4'd13; Divisor = 4'd4; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst quotient", int'(Quotient), 0);
        chk("async_rst remainder", int'(Remainder), 0);
        chk("async_rst busy", int'(Busy), 0);
        chk("async_rst done", int'(Done), 0);
        chk("async_rst divbyzero", int'(DivByZero), 0);
        #3 rst_n = 1'b1;
        tick();
        run_div(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 4, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
